mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: W, default `WORD_WIDTH (32), operand/result width; SHALL be an even value >= 4.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled on rising clk edge.
REQ-005 Port: mdu_op  input  3  op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved.
REQ-006 Port: op1  input  W  multiplicand/dividend, or the MTHI/MTLO source.
REQ-007 Port: op2  input  W  multiplier/divisor.
REQ-008 Port: flush  input  1  abort any in-flight operation (pipeline exception/squash).
REQ-009 Port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when hi/lo have just been updated.
REQ-011 Port: hi  output  W  HI register (product upper half / remainder).
REQ-012 Port: lo  output  W  LO register (product lower half / quotient).

Function
REQ-013 FSM states: IDLE, CALC; iteration counter counts 0..W-1.
REQ-014 Accept: a request is accepted on an edge where state=IDLE, start=1, flush=0 and mdu_op is in 1..6; otherwise start is ignored and causes no state change.
REQ-015 op1, op2 and mdu_op SHALL be latched on accept; changes to these inputs during CALC SHALL have no effect.
REQ-016 MTHI/MTLO: hi (resp. lo) <= op1 on the accepting edge; the FSM stays in IDLE; done=1 for the next cycle; busy stays 0.
REQ-017 MULT/MULTU/DIV/DIVU: the FSM enters CALC on the accepting edge with busy=1; one radix-2 iteration is performed per edge; after the W-th CALC edge, hi/lo are written, the FSM returns to IDLE, busy=0 and done=1 for one cycle.
REQ-018 Total latency SHALL be exactly W+1 edges from accept to the done cycle; busy is high for exactly W cycles.
REQ-019 Multiply: {hi,lo} = full 2W-bit product; MULTU treats operands as unsigned; MULT produces the two's-complement signed product.
REQ-020 Divide: the divider is restoring, operating on magnitudes; lo = quotient, hi = remainder.
REQ-021 DIV signs: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign (truncation toward zero).
REQ-022 Divide by zero (either signedness): full W-cycle latency; lo = all ones, hi = op1 as latched; no exception.
REQ-023 DIV with op1 = most-negative and op2 = -1: lo = most-negative value, hi = 0; no exception.
REQ-024 Accepting a new request in the same cycle that done=1 SHALL be allowed (back-to-back).
REQ-025 flush=1 in CALC: return to IDLE on that edge with busy=0; hi/lo unchanged; no done pulse.
REQ-026 flush=1 in IDLE: blocks acceptance on that edge; flush has priority over start.
REQ-027 hi/lo SHALL change only on completion of a MULT/MULTU/DIV/DIVU, on accept of MTHI/MTLO, or on reset.

Reset
REQ-028 On rst=1, immediately and independent of clk: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, all internal datapath registers cleared.
REQ-029 Reset asserted during CALC SHALL abort the operation with no done pulse; the first request after reset release is accepted normally.

Verification (W=32)
REQ-030 MULT op1=0xFFFFFFFE, op2=3 -> busy for 32 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 MULTU op1=op2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT on the same operands -> hi=0, lo=1.
REQ-032 DIV op1=0xFFFFFFF9 (-7), op2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; op1/op2 toggled during busy do not change the result.
REQ-034 DIV started, flush at the 10th CALC cycle -> busy=0 next cycle, no done, hi/lo hold; then MTHI 0x12345678 -> hi=0x12345678, done one cycle, busy never 1.
REQ-035 MULT started, rst pulsed mid-CALC, asynchronous to clk -> hi=lo=0, busy=done=0 immediately; start ignored while busy.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one accumulator, with MTHI/MTLO moves and a HI/LO result pair.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mdu_iter #(
    parameter int W = `WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   mdu_op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {S_IDLE, S_CALC} state_e;

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept, finish;

    op_e  op_in;
    logic op_long, op_valid, op_signed;
    logic a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;

    assign op_in     = op_e'(mdu_op);
    assign op_long   = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                       (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign op_valid  = op_long || (op_in == OP_MTHI) || (op_in == OP_MTLO);
    assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign a_neg     = op_signed & op1[W-1];
    assign b_neg     = op_signed & op2[W-1];
    assign a_mag     = a_neg ? -op1 : op1;
    assign b_mag     = b_neg ? -op2 : op2;

    // Datapath: acc is the running high half (product) or partial remainder (divide);
    // quo holds the multiplier bits being consumed or the quotient being built.
    logic         mul_q, neg_res, neg_rem;
    logic [W:0]   acc;
    logic [W-1:0] quo, dsr, op1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !flush && op_valid) begin
                    accept = 1'b1;
                    if (op_long) state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(W - 1)) begin
                    finish    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_CALC);

    logic [W:0]     mul_sum, shifted, diff, step_acc;
    logic [W-1:0]   step_lo, q_s, r_s, res_hi, res_lo;
    logic [2*W-1:0] prod, prod_s;
    logic           ge;

    always_comb begin
        mul_sum = quo[0] ? acc + {1'b0, dsr} : acc;
        shifted = {acc[W-1:0], quo[W-1]};
        ge      = (shifted >= {1'b0, dsr});
        diff    = shifted - {1'b0, dsr};
        if (mul_q) begin
            step_acc = {1'b0, mul_sum[W:1]};
            step_lo  = {mul_sum[0], quo[W-1:1]};
        end else begin
            step_acc = ge ? diff : shifted;
            step_lo  = {quo[W-2:0], ge};
        end
        prod   = {step_acc[W-1:0], step_lo};
        prod_s = neg_res ? -prod : prod;
        q_s    = neg_res ? -step_lo : step_lo;
        r_s    = neg_rem ? -step_acc[W-1:0] : step_acc[W-1:0];
        // Divide by zero reports all-ones quotient and the untouched dividend.
        if (mul_q) begin
            res_hi = prod_s[2*W-1:W];
            res_lo = prod_s[W-1:0];
        end else if (dsr == '0) begin
            res_hi = op1_q;
            res_lo = '1;
        end else begin
            res_hi = r_s;
            res_lo = q_s;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            quo     <= '0;
            dsr     <= '0;
            op1_q   <= '0;
            mul_q   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                unique case (op_in)
                    OP_MTHI: begin
                        hi   <= op1;
                        done <= 1'b1;
                    end
                    OP_MTLO: begin
                        lo   <= op1;
                        done <= 1'b1;
                    end
                    default: begin
                        cnt     <= '0;
                        acc     <= '0;
                        quo     <= a_mag;
                        dsr     <= b_mag;
                        op1_q   <= op1;
                        mul_q   <= (op_in == OP_MULT) || (op_in == OP_MULTU);
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                    end
                endcase
            end else if (busy) begin
                if (flush) begin
                    cnt <= '0;
                end else begin
                    acc <= step_acc;
                    quo <= step_lo;
                    cnt <= finish ? '0 : cnt + CW'(1);
                    if (finish) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a transaction-level reference model checked every cycle,
// plus hand-computed expectations for each directed operation.
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, flush;
    logic [2:0]   mdu_op;
    logic [W-1:0] op1, op2;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_iter #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op),
        .op1(op1), .op2(op2), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (op)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'b0, a} * {32'b0, b};
            3'd3, 3'd4: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 3'd3) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Transaction model: cycles remaining, pending result, architectural HI/LO.
    int          m_left;
    logic        m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (flush) begin
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_left <= 0;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush && mdu_op >= 3'd1 && mdu_op <= 3'd6) begin
                if (mdu_op == 3'd5) begin
                    m_hi   <= op1;
                    m_done <= 1'b1;
                end else if (mdu_op == 3'd6) begin
                    m_lo   <= op1;
                    m_done <= 1'b1;
                end else begin
                    m_res  <= ref_result(mdu_op, op1, op2);
                    m_left <= W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("cyc_busy", 64'(busy), 64'(m_left != 0));
            check("cyc_done", 64'(done), 64'(m_done));
            check("cyc_hi",   64'(hi),   64'(m_hi));
            check("cyc_lo",   64'(lo),   64'(m_lo));
        end
    end

    // Called just after a falling edge; returns on the falling edge inside the done cycle,
    // so a following call issues its request back-to-back.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_busy, input bit toggle);
        int nb;
        bit got;
        nb  = 0;
        got = 1'b0;
        mdu_op = op;
        op1    = a;
        op2    = b;
        start  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (toggle) begin
                op1    = $urandom;
                op2    = $urandom;
                mdu_op = 3'($urandom_range(1, 6));
            end
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({name, "_hi"}, 64'(hi), 64'(exp_hi));
            check({name, "_lo"}, 64'(lo), 64'(exp_lo));
            check({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        end
    endtask

    initial begin
        int nb, nd;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        mdu_op = 3'd0;
        op1    = '0;
        op2    = '0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        #20;
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_neg2x3",   3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 32, 1'b0);
        run_op("multu_max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 1'b0);
        run_op("mult_m1xm1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32, 1'b0);
        run_op("div_m7_2",      3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 1'b0);
        run_op("divu_7_0",      3'd4, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 32, 1'b0);
        run_op("div_ovf_tog",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32, 1'b1);
        run_op("div_m5_0",      3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32, 1'b0);
        run_op("divu_100_7",    3'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 32, 1'b0);
        run_op("div_7_m2",      3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 32, 1'b0);
        run_op("mult_minxmin",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32, 1'b0);

        // NOP and reserved codes, then a flushed MTHI, must all be ignored.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'd0; op1 = 32'hDEAD_BEEF;
        @(negedge clk);
        mdu_op = 3'd7;
        @(negedge clk);
        mdu_op = 3'd5; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("ignored_busy", 64'(busy), 64'd0);
        check("ignored_done", 64'(done), 64'd0);
        check("ignored_hi",   64'(hi),   64'h4000_0000);

        // DIV flushed in its 10th CALC cycle; an MTHI request while busy is ignored.
        nb = 0;
        mdu_op = 3'd3; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nb++;
            if (nb == 5 && busy) begin
                start = 1'b1; mdu_op = 3'd5; op1 = 32'h0000_0BAD;
            end
            if (nb == 10) begin
                flush = 1'b1;
                break;
            end
        end
        check("flush_reached_10", 64'(nb), 64'd10);
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("flush_no_done", 64'(nd), 64'd0);
        check("flush_hi_hold", 64'(hi), 64'h4000_0000);
        check("flush_lo_hold", 64'(lo), 64'h0000_0000);

        run_op("mthi", 3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0000_0000, 0, 1'b0);
        run_op("mtlo", 3'd6, 32'hCAFE_BABE, 32'd0, 32'h1234_5678, 32'hCAFE_BABE, 0, 1'b0);

        // Asynchronous reset in the middle of a MULT.
        @(negedge clk);
        mdu_op = 3'd1; op1 = 32'd3; op2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_done", 64'(done), 64'd0);
        check("async_rst_hi",   64'(hi),   64'd0);
        check("async_rst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_start_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("multu_after_rst", 3'd2, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 32, 1'b0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
